// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// Builds with the optional tick synchronizer when STOPWATCH_SYNC_EN is defined.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] UNITS_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Using >= keeps the digit legal even if it somehow held a value above its limit.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d,
                                                 input logic [DIGIT_W-1:0] lim);
    return (d >= lim) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the divider's square wave into a one-cycle tick_rise strobe.
// With STOPWATCH_SYNC_EN a two-flop synchronizer sits in front of the edge flop.
module tick_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_in,
  output logic tick_rise
);

`ifdef STOPWATCH_SYNC_EN
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], tick_in};
      prev <= sync[1];
    end
  end

  assign tick_rise = sync[1] & ~prev;
`else
  // tick_in is already in the clk_in domain, so it is sampled directly.
  logic prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= tick_in;
  end

  assign tick_rise = tick_in & ~prev;
`endif

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch: start/stop/clear FSM driving a four-digit BCD counter.
// STOPWATCH_SYNC_EN selects the synchronized tick path inside tick_edge_detect.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               start_stop,
  input  logic               clear,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               running,
  output logic               wrap,
  output state_t             state
);

  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = DIGIT_W'(MAX_MIN_TENS);

  logic               tick_rise;
  logic [DIGIT_W-1:0] sec_ones_n, sec_tens_n, min_ones_n, min_tens_n;
  logic               carry_so, carry_st, carry_mo, at_max;

  tick_edge_detect u_tick (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_in   (tick_in),
    .tick_rise (tick_rise)
  );

  // Ripple carries are decoded from the current digits so all four update together.
  always_comb begin
    carry_so   = (sec_ones == UNITS_MAX);
    carry_st   = carry_so & (sec_tens == SEC_TENS_MAX);
    carry_mo   = carry_st & (min_ones == UNITS_MAX);
    at_max     = carry_mo & (min_tens >= MIN_TENS_MAX);
    sec_ones_n = bcd_inc(sec_ones, UNITS_MAX);
    sec_tens_n = carry_so ? bcd_inc(sec_tens, SEC_TENS_MAX) : sec_tens;
    min_ones_n = carry_st ? bcd_inc(min_ones, UNITS_MAX)    : min_ones;
    min_tens_n = carry_mo ? bcd_inc(min_tens, MIN_TENS_MAX) : min_tens;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      wrap     <= 1'b0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state    <= ST_IDLE;
        running  <= 1'b0;
        sec_ones <= '0;
        sec_tens <= '0;
        min_ones <= '0;
        min_tens <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            if (start_stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (tick_rise) begin
              sec_ones <= sec_ones_n;
              sec_tens <= sec_tens_n;
              min_ones <= min_ones_n;
              min_tens <= min_tens_n;
              wrap     <= at_max;
            end
            if (start_stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start_stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
          end
        endcase
      end
    end
  end

endmodule
